// File: rtl/alu_fsm_pkg.sv
//------------------------------------------------------------------------------
// Module  : alu_fsm_pkg
// Brief   : State encoding and instruction-class codes shared by the ALU
//           execution sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_fsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_A = 3'd1,
        ST_FETCH_B = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_FINISH  = 3'd5
    } state_t;

    localparam logic [1:0] CLS_RR         = 2'b00;
    localparam logic [1:0] CLS_RI         = 2'b01;
    localparam logic [3:0] CMP_OP_DEFAULT = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/imm_extend.sv
//------------------------------------------------------------------------------
// Module  : imm_extend
// Brief   : Widens an IMM_W immediate to DATA_W by sign or zero extension.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imm_extend #(
    parameter int IMM_W    = 6,
    parameter int DATA_W   = 16,
    parameter int SIGN_EXT = 1
) (
    input  logic [IMM_W-1:0]  imm_i,
    output logic [DATA_W-1:0] ext_o
);

    generate
        if (IMM_W == DATA_W) begin : g_pass
            assign ext_o = imm_i;
        end else begin : g_ext
            logic w_fill;
            assign w_fill = (SIGN_EXT != 0) ? imm_i[IMM_W-1] : 1'b0;
            assign ext_o  = {{(DATA_W-IMM_W){w_fill}}, imm_i};
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/alu_exec_fsm.sv
//------------------------------------------------------------------------------
// Module  : alu_exec_fsm
// Brief   : Sequences operand fetch, ALU execution and write-back for one
//           latched instruction, issuing one-hot datapath strobes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_exec_fsm
    import alu_fsm_pkg::*;
#(
    parameter int              DATA_W      = 16,
    parameter int              REG_AW      = 4,
    parameter int              OP_W        = 4,
    parameter int              INSTR_W     = 16,
    parameter int              EXEC_CYCLES = 1,
    parameter int              SIGN_EXT    = 1,
    parameter logic [OP_W-1:0] CMP_OP      = OP_W'(CMP_OP_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [OP_W-1:0]    aluOp,
    output logic [REG_AW-1:0]  rxOut,
    output logic               ALUin0,
    output logic               ALUin1,
    output logic               ALUImmOut,
    output logic [DATA_W-1:0]  param2Out,
    output logic               ALUoutlatch,
    output logic               ALUoutEN,
    output logic [REG_AW-1:0]  rxIn,
    output logic               pcInc
);

    localparam int IMM_W = INSTR_W - 2 - OP_W - REG_AW;
    localparam int CNT_W = 4;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [1:0]         w_cls;
    logic [1:0]         w_in_cls;
    logic [OP_W-1:0]    w_op;
    logic [REG_AW-1:0]  w_rd;
    logic [IMM_W-1:0]   w_imm;
    logic [REG_AW-1:0]  w_rs;
    logic [DATA_W-1:0]  w_ext;
    logic               w_legal;
    logic               w_in_legal;

    assign w_cls      = instr_q[INSTR_W-1 -: 2];
    assign w_op       = instr_q[INSTR_W-3 -: OP_W];
    assign w_rd       = instr_q[INSTR_W-3-OP_W -: REG_AW];
    assign w_imm      = instr_q[IMM_W-1:0];
    assign w_rs       = w_imm[IMM_W-1 -: REG_AW];
    assign w_legal    = (w_cls == CLS_RR) || (w_cls == CLS_RI);
    assign w_in_cls   = instruction[INSTR_W-1 -: 2];
    assign w_in_legal = (w_in_cls == CLS_RR) || (w_in_cls == CLS_RI);

    imm_extend #(
        .IMM_W    (IMM_W),
        .DATA_W   (DATA_W),
        .SIGN_EXT (SIGN_EXT)
    ) u_imm_extend (
        .imm_i (w_imm),
        .ext_o (w_ext)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign aluOp = busy ? w_op : '0;

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        cnt_d       = cnt_q;
        done        = 1'b0;
        illegal     = 1'b0;
        rxOut       = '0;
        ALUin0      = 1'b0;
        ALUin1      = 1'b0;
        ALUImmOut   = 1'b0;
        param2Out   = '0;
        ALUoutlatch = 1'b0;
        ALUoutEN    = 1'b0;
        rxIn        = '0;
        pcInc       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    instr_d = instruction;
                    // Illegal classes skip the datapath entirely.
                    state_d = w_in_legal ? ST_FETCH_A : ST_FINISH;
                end
            end
            ST_FETCH_A: begin
                rxOut   = w_rd;
                ALUin0  = 1'b1;
                state_d = ST_FETCH_B;
            end
            ST_FETCH_B: begin
                ALUin1 = 1'b1;
                if (w_cls == CLS_RI) begin
                    ALUImmOut = 1'b1;
                    param2Out = w_ext;
                end else begin
                    rxOut = w_rs;
                end
                cnt_d   = CNT_W'(EXEC_CYCLES - 1);
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    ALUoutlatch = 1'b1;
                    state_d     = (w_op == CMP_OP) ? ST_FINISH : ST_WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WRITE: begin
                ALUoutEN = 1'b1;
                rxIn     = w_rd;
                state_d  = ST_FINISH;
            end
            ST_FINISH: begin
                done    = 1'b1;
                pcInc   = 1'b1;
                illegal = ~w_legal;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_fsm.sv
//------------------------------------------------------------------------------
// Module  : tb_alu_exec_fsm
// Brief   : Directed bench for alu_exec_fsm; a default instance and an
//           EXEC_CYCLES=3 / zero-extend instance share the same stimulus.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_fsm;

    // Strobe vector: {busy, ALUin0, ALUin1, ALUImmOut, ALUoutlatch, ALUoutEN, done, pcInc, illegal}
    localparam logic [8:0] S_IDLE   = 9'h000;
    localparam logic [8:0] S_FA     = 9'h180;
    localparam logic [8:0] S_FB_RI  = 9'h160;
    localparam logic [8:0] S_FB_RR  = 9'h140;
    localparam logic [8:0] S_EX     = 9'h100;
    localparam logic [8:0] S_EXL    = 9'h110;
    localparam logic [8:0] S_WR     = 9'h108;
    localparam logic [8:0] S_FIN    = 9'h106;
    localparam logic [8:0] S_FINILL = 9'h107;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] instruction = 16'h0;

    logic        busy0, done0, ill0, ain0_0, ain1_0, imm0, lat0, oen0, pc0;
    logic [3:0]  op0, rxo0, rxi0;
    logic [15:0] p2_0;
    logic        busy1, done1, ill1, ain0_1, ain1_1, imm1, lat1, oen1, pc1;
    logic [3:0]  op1, rxo1, rxi1;
    logic [15:0] p2_1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_exec_fsm u_dut (
        .clk (clk), .rst (rst), .start (start), .instruction (instruction),
        .busy (busy0), .done (done0), .illegal (ill0), .aluOp (op0),
        .rxOut (rxo0), .ALUin0 (ain0_0), .ALUin1 (ain1_0), .ALUImmOut (imm0),
        .param2Out (p2_0), .ALUoutlatch (lat0), .ALUoutEN (oen0),
        .rxIn (rxi0), .pcInc (pc0)
    );

    alu_exec_fsm #(.EXEC_CYCLES (3), .SIGN_EXT (0)) u_dut3 (
        .clk (clk), .rst (rst), .start (start), .instruction (instruction),
        .busy (busy1), .done (done1), .illegal (ill1), .aluOp (op1),
        .rxOut (rxo1), .ALUin0 (ain0_1), .ALUin1 (ain1_1), .ALUImmOut (imm1),
        .param2Out (p2_1), .ALUoutlatch (lat1), .ALUoutEN (oen1),
        .rxIn (rxi1), .pcInc (pc1)
    );

    function automatic logic [36:0] ex(input logic [8:0] s, input logic [3:0] op,
                                       input logic [3:0] ro, input logic [3:0] ri,
                                       input logic [15:0] p);
        return {s, op, ro, ri, p};
    endfunction

    function automatic logic [36:0] obs0();
        return {busy0, ain0_0, ain1_0, imm0, lat0, oen0, done0, pc0, ill0, op0, rxo0, rxi0, p2_0};
    endfunction

    function automatic logic [36:0] obs1();
        return {busy1, ain0_1, ain1_1, imm1, lat1, oen1, done1, pc1, ill1, op1, rxo1, rxi1, p2_1};
    endfunction

    task automatic check_eq(input string tag, input logic [36:0] got, input logic [36:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        check_eq("reset_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("reset_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        rst = 1'b1;
        step();

        // reg-imm op0 rd9 imm4; instruction scrambled after acceptance
        instruction = 16'h4244; start = 1'b1;
        step();
        check_eq("ri_fa_d0", obs0(), ex(S_FA, 4'h0, 4'd9, 4'h0, 16'h0));
        check_eq("ri_fa_d1", obs1(), ex(S_FA, 4'h0, 4'd9, 4'h0, 16'h0));
        start = 1'b0; instruction = 16'h0000;
        step();
        check_eq("ri_fb_d0", obs0(), ex(S_FB_RI, 4'h0, 4'h0, 4'h0, 16'h0004));
        check_eq("ri_fb_d1", obs1(), ex(S_FB_RI, 4'h0, 4'h0, 4'h0, 16'h0004));
        step();
        check_eq("ri_c3_d0", obs0(), ex(S_EXL, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("ri_c3_d1", obs1(), ex(S_EX, 4'h0, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("ri_c4_d0", obs0(), ex(S_WR, 4'h0, 4'h0, 4'd9, 16'h0));
        check_eq("ri_c4_d1", obs1(), ex(S_EX, 4'h0, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("ri_c5_d0", obs0(), ex(S_FIN, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("ri_c5_d1", obs1(), ex(S_EXL, 4'h0, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("ri_c6_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("ri_c6_d1", obs1(), ex(S_WR, 4'h0, 4'h0, 4'd9, 16'h0));
        step();
        check_eq("ri_c7_d1", obs1(), ex(S_FIN, 4'h0, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("ri_c8_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));

        // reg-imm op1 rd3 imm 3C; start held through FINISH, re-accepted in IDLE
        instruction = 16'h44FC; start = 1'b1;
        step();
        check_eq("ext_fa_d0", obs0(), ex(S_FA, 4'h1, 4'd3, 4'h0, 16'h0));
        check_eq("ext_fa_d1", obs1(), ex(S_FA, 4'h1, 4'd3, 4'h0, 16'h0));
        step();
        check_eq("sext_d0", obs0(), ex(S_FB_RI, 4'h1, 4'h0, 4'h0, 16'hFFFC));
        check_eq("zext_d1", obs1(), ex(S_FB_RI, 4'h1, 4'h0, 4'h0, 16'h003C));
        step();
        step();
        step();
        check_eq("hold_fin_d0", obs0(), ex(S_FIN, 4'h1, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("hold_idle_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("hold_wr_d1", obs1(), ex(S_WR, 4'h1, 4'h0, 4'd3, 16'h0));
        step();
        check_eq("b2b_fa_d0", obs0(), ex(S_FA, 4'h1, 4'd3, 4'h0, 16'h0));
        check_eq("hold_fin_d1", obs1(), ex(S_FIN, 4'h1, 4'h0, 4'h0, 16'h0));
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_eq("b2b_end_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("b2b_end_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));

        // reg-reg compare: op F rd5 rs10, no write-back
        instruction = 16'h3D68; start = 1'b1;
        step();
        check_eq("cmp_fa_d0", obs0(), ex(S_FA, 4'hF, 4'd5, 4'h0, 16'h0));
        start = 1'b0;
        step();
        check_eq("cmp_fb_d0", obs0(), ex(S_FB_RR, 4'hF, 4'd10, 4'h0, 16'h0));
        step();
        check_eq("cmp_ex_d0", obs0(), ex(S_EXL, 4'hF, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("cmp_fin_d0", obs0(), ex(S_FIN, 4'hF, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("cmp_idle_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("cmp_fin_d1", obs1(), ex(S_FIN, 4'hF, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("cmp_idle_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));

        // illegal class 2'b10, opcode C
        instruction = 16'hB000; start = 1'b1;
        step();
        check_eq("ill_fin_d0", obs0(), ex(S_FINILL, 4'hC, 4'h0, 4'h0, 16'h0));
        check_eq("ill_fin_d1", obs1(), ex(S_FINILL, 4'hC, 4'h0, 4'h0, 16'h0));
        start = 1'b0;
        step();
        check_eq("ill_idle_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("ill_idle_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));

        // reset during EXEC with start held high
        instruction = 16'h4244; start = 1'b1;
        step();
        step();
        step();
        check_eq("abort_pre_d0", obs0(), ex(S_EXL, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("abort_pre_d1", obs1(), ex(S_EX, 4'h0, 4'h0, 4'h0, 16'h0));
        rst = 1'b0;
        step();
        check_eq("abort_r1_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("abort_r1_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("abort_r2_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("abort_r2_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        rst = 1'b1; start = 1'b0;
        step();
        check_eq("abort_p1_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("abort_p1_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        step();
        check_eq("abort_p2_d0", obs0(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));
        check_eq("abort_p2_d1", obs1(), ex(S_IDLE, 4'h0, 4'h0, 4'h0, 16'h0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
